// File: rtl/lap_buffer_ctrl.sv
// lap_buffer_ctrl: lap-time memory controller for the stopwatch.
// Captures live BCD time into a DEPTH-entry circular buffer on store
// flags and replays it newest-to-oldest on read flags.
//
// Ports:
//   sys_clk, rst_n   clock, asynchronous active-low reset
//   sta_sto_flag     1-cycle pulse, start/stop key (leaves HIST)
//   store_flag       1-cycle pulse, capture data_in (LIVE only)
//   read_flag        1-cycle pulse, enter / step through HIST
//   clr_flag         1-cycle pulse, forget all stored laps
//   data_in          live time word from the counter
//   disp_data        registered word to display
//   disp_mode        0 = live time, 1 = history
//   lap_no           1 = newest lap in HIST, 0 in LIVE
//   lap_cnt          valid entries, saturates at DEPTH
//   overflow         sticky, an entry was overwritten since last clear
//
// Optional feature: define LAP_AUTO_EXIT_EN to build a 28-bit idle
// counter that drops HIST back to LIVE after TIMEOUT_CYC idle cycles.

module lap_buffer_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
`ifdef LAP_AUTO_EXIT_EN
    ,
    parameter int TIMEOUT_CYC = 250_000_000
`endif
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              sta_sto_flag,
    input  logic              store_flag,
    input  logic              read_flag,
    input  logic              clr_flag,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_mode,
    output logic [ADDR_W:0]   lap_no,
    output logic [ADDR_W:0]   lap_cnt,
    output logic              overflow
);

    localparam logic [0:0] LIVE = 1'b0;
    localparam logic [0:0] HIST = 1'b1;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   lap_cnt_q, lap_cnt_d;
    logic [ADDR_W:0]   lap_no_q, lap_no_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // One-hot action after priority resolution: clr > sta_sto > read > store.
    logic act_clr, act_ss, act_rd, act_st;

    assign act_clr = clr_flag;
    assign act_ss  = sta_sto_flag & ~clr_flag;
    assign act_rd  = read_flag & ~sta_sto_flag & ~clr_flag;
    assign act_st  = store_flag & ~read_flag & ~sta_sto_flag & ~clr_flag;

`ifdef LAP_AUTO_EXIT_EN
    localparam logic [27:0] IDLE_LAST = 28'(TIMEOUT_CYC - 1);
    logic [27:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lap_cnt_d = lap_cnt_q;
        lap_no_d  = lap_no_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;

        unique case (1'b1)
            act_clr: begin
                state_d   = LIVE;
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                lap_cnt_d = '0;
                lap_no_d  = '0;
                ovf_d     = 1'b0;
            end
            act_ss: begin
                if (state_q == HIST) begin
                    state_d  = LIVE;
                    lap_no_d = '0;
                end
            end
            act_rd: begin
                if (state_q == LIVE) begin
                    if (lap_cnt_q != '0) begin
                        state_d  = HIST;
                        rd_ptr_d = wr_ptr_q - PTR_ONE;
                        lap_no_d = CNT_ONE;
                    end
                end else if (lap_no_q < lap_cnt_q) begin
                    rd_ptr_d = rd_ptr_q - PTR_ONE;
                    lap_no_d = lap_no_q + CNT_ONE;
                end else begin
                    // Oldest entry already shown: wrap back to live time.
                    state_d  = LIVE;
                    lap_no_d = '0;
                end
            end
            act_st: begin
                if (state_q == LIVE) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (lap_cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        lap_cnt_d = lap_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
            end
        endcase

`ifdef LAP_AUTO_EXIT_EN
        // Counts only HIST cycles without a state-affecting key; a read
        // (or any exit) reloads it to zero.
        idle_d = '0;
        if (state_q == HIST && !act_clr && !act_ss && !act_rd) begin
            if (idle_q == IDLE_LAST) begin
                state_d  = LIVE;
                lap_no_d = '0;
            end else begin
                idle_d = idle_q + 28'd1;
            end
        end
`endif

        // Look up with the next read pointer so the word lands on the same
        // edge that raises disp_mode; no write can hit that slot this cycle.
        if (state_d == HIST) begin
            disp_data_d = mem[rd_ptr_d];
        end else begin
            disp_data_d = data_in;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LIVE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lap_cnt_q   <= '0;
            lap_no_q    <= '0;
            ovf_q       <= 1'b0;
            disp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lap_cnt_q   <= lap_cnt_d;
            lap_no_q    <= lap_no_d;
            ovf_q       <= ovf_d;
            disp_data_q <= disp_data_d;
        end
    end

`ifdef LAP_AUTO_EXIT_EN
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign disp_data = disp_data_q;
    assign disp_mode = state_q;
    assign lap_no    = lap_no_q;
    assign lap_cnt   = lap_cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_lap_buffer_ctrl.sv
// tb_lap_buffer_ctrl: directed and randomized bench for lap_buffer_ctrl
// against a queue-based model of the lap memory.

module tb_lap_buffer_ctrl;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 20;

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sta_sto_flag = 1'b0;
    logic              store_flag = 1'b0;
    logic              read_flag = 1'b0;
    logic              clr_flag = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_mode;
    logic [ADDR_W:0]   lap_no;
    logic [ADDR_W:0]   lap_cnt;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Model: stored laps oldest-first, history position, sticky overflow.
    logic [DATA_W-1:0] m_laps [$];
    bit                m_ovf;
    bit                m_hist;
    int                m_lapno;
    int                m_idle;
    logic [DATA_W-1:0] m_disp;

    lap_buffer_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
`ifdef LAP_AUTO_EXIT_EN
        ,
        .TIMEOUT_CYC(TIMEOUT)
`endif
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .sta_sto_flag(sta_sto_flag),
        .store_flag(store_flag),
        .read_flag(read_flag),
        .clr_flag(clr_flag),
        .data_in(data_in),
        .disp_data(disp_data),
        .disp_mode(disp_mode),
        .lap_no(lap_no),
        .lap_cnt(lap_cnt),
        .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void model_reset();
        m_laps.delete();
        m_ovf   = 1'b0;
        m_hist  = 1'b0;
        m_lapno = 0;
        m_idle  = 0;
        m_disp  = '0;
    endfunction

    function automatic void model_step(bit clr, bit ss, bit rd, bit st,
                                       logic [DATA_W-1:0] din);
        if (clr) begin
            m_laps.delete();
            m_ovf   = 1'b0;
            m_hist  = 1'b0;
            m_lapno = 0;
        end else if (ss) begin
            if (m_hist) begin
                m_hist  = 1'b0;
                m_lapno = 0;
            end
        end else if (rd) begin
            if (!m_hist) begin
                if (m_laps.size() > 0) begin
                    m_hist  = 1'b1;
                    m_lapno = 1;
                    m_idle  = 0;
                end
            end else if (m_lapno < m_laps.size()) begin
                m_lapno++;
                m_idle = 0;
            end else begin
                m_hist  = 1'b0;
                m_lapno = 0;
            end
        end else begin
            if (st && !m_hist) begin
                if (m_laps.size() == DEPTH) begin
                    void'(m_laps.pop_front());
                    m_ovf = 1'b1;
                end
                m_laps.push_back(din);
            end
`ifdef LAP_AUTO_EXIT_EN
            if (m_hist) begin
                if (m_idle == TIMEOUT - 1) begin
                    m_hist  = 1'b0;
                    m_lapno = 0;
                end else begin
                    m_idle++;
                end
            end
`endif
        end
        m_disp = m_hist ? m_laps[m_laps.size() - m_lapno] : din;
    endfunction

    task automatic step(bit clr, bit ss, bit rd, bit st,
                        logic [DATA_W-1:0] din);
        @(negedge sys_clk);
        clr_flag     = clr;
        sta_sto_flag = ss;
        read_flag    = rd;
        store_flag   = st;
        data_in      = din;
        @(posedge sys_clk);
        #1;
        model_step(clr, ss, rd, st, din);
        clr_flag     = 1'b0;
        sta_sto_flag = 1'b0;
        read_flag    = 1'b0;
        store_flag   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        data_in = 32'h1234_5678;
        repeat (2) @(posedge sys_clk);
        #1;
        model_reset();
        checks++;
        if ({disp_data, disp_mode, lap_no, lap_cnt, overflow} !== '0) begin
            errors++;
            $display("FAIL reset got data=%h mode=%b no=%0d cnt=%0d ovf=%b need all 0",
                     disp_data, disp_mode, lap_no, lap_cnt, overflow);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_read();
        logic [DATA_W-1:0] exp_w [3];
        exp_w[0] = 32'h333;
        exp_w[1] = 32'h210;
        exp_w[2] = 32'h105;
        step(0, 0, 0, 1, 32'h105);
        step(0, 0, 0, 1, 32'h210);
        step(0, 0, 0, 1, 32'h333);
        checks++;
        if (lap_cnt !== 4'd3 || overflow !== 1'b0 || disp_mode !== 1'b0) begin
            errors++;
            $display("FAIL store3 got cnt=%0d ovf=%b mode=%b need 3 0 0",
                     lap_cnt, overflow, disp_mode);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 32'h999);
            checks++;
            if (disp_data !== exp_w[i] || lap_no !== 4'(i + 1) || disp_mode !== 1'b1) begin
                errors++;
                $display("FAIL read%0d got data=%h no=%0d mode=%b need %h %0d 1",
                         i, disp_data, lap_no, disp_mode, exp_w[i], i + 1);
            end
        end
        step(0, 0, 1, 0, 32'h777);
        checks++;
        if (disp_mode !== 1'b0 || lap_no !== 4'd0 || disp_data !== 32'h777) begin
            errors++;
            $display("FAIL read_exit got mode=%b no=%0d data=%h need 0 0 777",
                     disp_mode, lap_no, disp_data);
        end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 0, 32'h0);
        for (int v = 1; v <= 10; v++) step(0, 0, 0, 1, 32'(v));
        checks++;
        if (lap_cnt !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_cnt got cnt=%0d ovf=%b need 8 1", lap_cnt, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 32'h0);
            checks++;
            if (disp_data !== 32'(10 - i) || lap_no !== 4'(i + 1)) begin
                errors++;
                $display("FAIL ovf_read%0d got data=%0d no=%0d need %0d %0d",
                         i, disp_data, lap_no, 10 - i, i + 1);
            end
        end
        step(0, 0, 1, 0, 32'h0);
        checks++;
        if (disp_mode !== 1'b0 || lap_no !== 4'd0) begin
            errors++;
            $display("FAIL ovf_exit got mode=%b no=%0d need 0 0", disp_mode, lap_no);
        end
    endtask

    task automatic test_empty_and_collide();
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h55);
        checks++;
        if (disp_mode !== 1'b0 || lap_no !== 4'd0 || lap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL empty_read got mode=%b no=%0d cnt=%0d need 0 0 0",
                     disp_mode, lap_no, lap_cnt);
        end
        step(0, 0, 0, 1, 32'hAA);
        step(0, 0, 1, 1, 32'hBB);
        checks++;
        if (disp_mode !== 1'b1 || disp_data !== 32'hAA ||
            lap_no !== 4'd1 || lap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL st_rd_same got mode=%b data=%h no=%0d cnt=%0d need 1 aa 1 1",
                     disp_mode, disp_data, lap_no, lap_cnt);
        end
        step(0, 1, 0, 0, 32'h0);
    endtask

    task automatic test_hist_controls();
        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 32'h100 + 32'(i));
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 1, 32'hDEAD);
        checks++;
        if (lap_cnt !== 4'd8 || disp_mode !== 1'b1 || disp_data !== 32'h108) begin
            errors++;
            $display("FAIL hist_store got cnt=%0d mode=%b data=%h need 8 1 108",
                     lap_cnt, disp_mode, disp_data);
        end
        step(0, 1, 0, 0, 32'h42);
        checks++;
        if (disp_mode !== 1'b0 || lap_no !== 4'd0 || disp_data !== 32'h42) begin
            errors++;
            $display("FAIL hist_stasto got mode=%b no=%0d data=%h need 0 0 42",
                     disp_mode, lap_no, disp_data);
        end
        step(0, 0, 1, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        checks++;
        if (lap_no !== 4'd2 || disp_data !== 32'h107) begin
            errors++;
            $display("FAIL hist_step2 got no=%0d data=%h need 2 107", lap_no, disp_data);
        end
        step(1, 1, 1, 1, 32'h0);
        checks++;
        if (disp_mode !== 1'b0 || lap_no !== 4'd0 ||
            lap_cnt !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL hist_clr got mode=%b no=%0d cnt=%0d ovf=%b need 0 0 0 0",
                     disp_mode, lap_no, lap_cnt, overflow);
        end
        step(0, 0, 0, 1, 32'h7);
        step(0, 0, 1, 0, 32'h0);
        @(negedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({disp_data, disp_mode, lap_no, lap_cnt, overflow} !== '0) begin
            errors++;
            $display("FAIL hist_rst got data=%h mode=%b no=%0d cnt=%0d ovf=%b need all 0",
                     disp_data, disp_mode, lap_no, lap_cnt, overflow);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

`ifdef LAP_AUTO_EXIT_EN
    task automatic test_auto_exit();
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h1);
        step(0, 0, 0, 1, 32'h2);
        step(0, 0, 1, 0, 32'h0);
        repeat (TIMEOUT - 1) step(0, 0, 0, 0, 32'h0);
        checks++;
        if (disp_mode !== 1'b1) begin
            errors++;
            $display("FAIL auto_early got mode=%b need 1", disp_mode);
        end
        step(0, 0, 0, 0, 32'h0);
        checks++;
        if (disp_mode !== 1'b0 || lap_no !== 4'd0) begin
            errors++;
            $display("FAIL auto_exit got mode=%b no=%0d need 0 0", disp_mode, lap_no);
        end
        step(0, 0, 1, 0, 32'h0);
        repeat (14) step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        repeat (TIMEOUT - 1) step(0, 0, 0, 0, 32'h0);
        checks++;
        if (disp_mode !== 1'b1 || lap_no !== 4'd2) begin
            errors++;
            $display("FAIL auto_reload got mode=%b no=%0d need 1 2", disp_mode, lap_no);
        end
        step(0, 0, 0, 0, 32'h0);
        checks++;
        if (disp_mode !== 1'b0) begin
            errors++;
            $display("FAIL auto_exit35 got mode=%b need 0", disp_mode);
        end
    endtask
`endif

    task automatic test_random();
        bit clr, ss, rd, st;
        logic [DATA_W-1:0] din;
        for (int n = 0; n < 800; n++) begin
            clr = ($urandom_range(0, 99) < 2);
            ss  = ($urandom_range(0, 99) < 8);
            rd  = ($urandom_range(0, 99) < 30);
            st  = ($urandom_range(0, 99) < 35);
            din = $urandom;
            step(clr, ss, rd, st, din);
            checks++;
            if (disp_data !== m_disp || disp_mode !== m_hist ||
                lap_no !== 4'(m_lapno) || lap_cnt !== 4'(m_laps.size()) ||
                overflow !== m_ovf) begin
                errors++;
                $display("FAIL random n=%0d got %h %b %0d %0d %b need %h %b %0d %0d %b",
                         n, disp_data, disp_mode, lap_no, lap_cnt, overflow,
                         m_disp, m_hist, m_lapno, m_laps.size(), m_ovf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_store_read();
        test_overflow();
        test_empty_and_collide();
        test_hist_controls();
`ifdef LAP_AUTO_EXIT_EN
        test_auto_exit();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
